wv_sequencer: RTL and testbench
===============================

Name: wv_sequencer

Overview:
- Autonomous write-verify controller for one 1T1R cell. It alternates verify reads (ADC, pcb mode WV_R) with SET/RESET pulses (pulse generator plus write DAC, pcb mode WV_W).
- It continues until the read current lies inside a target window or an iteration limit is reached.
- It talks to the ADC reader and the pulse generator through the existing toggle start/finish handshake. It replaces per-pulse I2C sequencing by the host.

Parameters:
ADC_W, 16, ADC sample width
ITER_W, 8, iteration counter width
SETTLE_CYC, 50, clk_in cycles held after any pcb_mode change before a request is issued
TIMEOUT_CYC, 300000, maximum clk_in cycles spent waiting for a finish toggle
W_MAX, 63, pulse width ceiling (6-bit field)

Ports:
clk_in  in  1  system clock
rstn  in  1  asynchronous active-low reset
go  in  1  1-cycle start strobe
abort  in  1  level; requests early termination
target  in  ADC_W  desired ADC code
tol  in  ADC_W  half window width
max_iter  in  ITER_W  maximum number of pulses; 0 means read-only check
w_init  in  6  initial pulse width
w_step  in  6  width increment per same-polarity repeat
pcb_mode  out  3  0=WV_R, 1=WV_W
pulse_dw  out  8  [7:6] 1=SET, 2=RESET, 0=idle; [5:0] width
adc_start  out  1  toggle request to ADC reader
adc_finish  in  1  toggle acknowledge from ADC reader
adc_data  in  ADC_W  sample; valid when adc_finish equals adc_start
pls_start  out  1  toggle request to pulse generator
pls_finish  in  1  toggle acknowledge from pulse generator
busy  out  1  high from the cycle after accepted go until done
done  out  1  1-cycle strobe at completion
status  out  2  0=PASS, 1=FAIL_ITER, 2=TIMEOUT, 3=ABORTED; held until next go
iter_cnt  out  ITER_W  pulses issued in the current or last run
last_adc  out  ADC_W  most recent sample

Behaviour:
- Reset values: pcb_mode=0, pulse_dw=0, adc_start=0, pls_start=0, busy=0, done=0, status=0, iter_cnt=0, last_adc=0, FSM=IDLE, internal counters=0.
- Reset mid-run returns the FSM to IDLE at once. The peer finish toggles are also reset, so the toggles stay consistent.
- Handshake: a request is one inversion of the start toggle. The FSM waits until finish==start. Only one request is outstanding at a time.
- Window: lo = target - tol, saturating at 0. hi = target + tol, saturating at 2^ADC_W-1. In-window means lo <= adc_data <= hi, inclusive on both bounds.
- States and transitions:
  - IDLE: go latches target, tol, max_iter, w_init and w_step; clears iter_cnt, status and the width state; sets busy=1; moves to SET_R. go while busy is ignored.
  - SET_R: pcb_mode=0, pulse_dw[7:6]=0. Counts SETTLE_CYC cycles, then moves to RD_REQ.
  - RD_REQ: toggles adc_start (1 cycle), then moves to RD_WAIT.
  - RD_WAIT: on finish==start, captures last_adc and moves to EVAL. If TIMEOUT_CYC cycles elapse first, moves to END with status=2.
  - EVAL (1 cycle), priority highest first:
    - abort → END, status=3.
    - In-window → END, status=0.
    - iter_cnt==max_iter → END, status=1.
    - Otherwise compute the next pulse and move to SET_W. Below lo selects SET; above hi selects RESET.
  - Width rule in EVAL: if the polarity equals the previous pulse's polarity, width = min(width + w_step, W_MAX) using a 7-bit sum. Otherwise (first pulse, or polarity changed) width = w_init.
  - SET_W: pcb_mode=1, pulse_dw = {pol, width}. Waits SETTLE_CYC cycles, then moves to PL_REQ.
  - PL_REQ: toggles pls_start and increments iter_cnt (saturating), then moves to PL_WAIT.
  - PL_WAIT: on finish==start, moves to SET_R. On timeout, moves to END with status=2.
  - END: pcb_mode=0, pulse_dw=0, busy=0, done=1 for 1 cycle, then IDLE.
- abort sampled in a WAIT state never cancels the outstanding request. The FSM drains the handshake (or times out), then ends with status=3. An abort in SET_R or SET_W moves to END directly (status=3).
- Simultaneous events:
  - go and abort in IDLE: go is accepted and abort is ignored that cycle.
  - Timeout and ack in the same cycle: the ack wins.
- Timeout counter is cleared on every entry to a WAIT state.

Test Plan:
- target=1000, tol=20, ADC returns 1010 on the first read → 0 pulses, status=0, iter_cnt=0, done after one read. pcb_mode stays 0 throughout.
- target=1000, tol=20, w_init=4, w_step=4, ADC returns 900, 940, 970, 985 → three SET pulses with widths 4, 8, 12; status=0, iter_cnt=3.
- ADC returns 1100 then 900 → RESET width 4, then SET width 4 (polarity change resets width). With max_iter=2 and a final read of 900 → status=1, iter_cnt=2.
- w_init=60, w_step=5, ADC stuck at 0, max_iter=3 → widths 60, 63, 63; status=1.
- Pulse generator never toggles pls_finish, with TIMEOUT_CYC=100 → done at 100 cycles after PL_REQ, status=2, pcb_mode=0.
- abort asserted in RD_WAIT → the ack is still consumed, status=3, and the next go starts cleanly with adc_start==adc_finish. A separate run with rstn asserted during PL_WAIT → all outputs at reset values the next cycle.

Source files
------------

// File: rtl/wv_sequencer.sv
`default_nettype none
// ============================================================================
// wv_sequencer : write-verify loop for one 1T1R cell (verify read, SET/RESET pulse)
// Revision     : 1.0
// ============================================================================
module wv_sequencer #(
    parameter int ADC_W       = 16,
    parameter int ITER_W      = 8,
    parameter int SETTLE_CYC  = 50,
    parameter int TIMEOUT_CYC = 300000,
    parameter int W_MAX       = 63
) (
    input  logic              clk_in,
    input  logic              rstn,
    input  logic              go,
    input  logic              abort,
    input  logic [ADC_W-1:0]  target,
    input  logic [ADC_W-1:0]  tol,
    input  logic [ITER_W-1:0] max_iter,
    input  logic [5:0]        w_init,
    input  logic [5:0]        w_step,
    output logic [2:0]        pcb_mode,
    output logic [7:0]        pulse_dw,
    output logic              adc_start,
    input  logic              adc_finish,
    input  logic [ADC_W-1:0]  adc_data,
    output logic              pls_start,
    input  logic              pls_finish,
    output logic              busy,
    output logic              done,
    output logic [1:0]        status,
    output logic [ITER_W-1:0] iter_cnt,
    output logic [ADC_W-1:0]  last_adc
);

    localparam int CNT_MAX = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [6:0]       WMAX7        = 7'(W_MAX);

    typedef enum logic [3:0] {
        S_IDLE, S_SET_R, S_RD_REQ, S_RD_WAIT, S_EVAL,
        S_SET_W, S_PL_REQ, S_PL_WAIT, S_END
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [ADC_W-1:0]  target_q, tol_q;
    logic [ITER_W-1:0] max_iter_q;
    logic [5:0]        w_init_q, w_step_q, width_q;
    logic [1:0]        prev_pol;
    logic              abort_seen;

    logic [ADC_W:0]    lo_diff, hi_sum;
    logic [ADC_W-1:0]  lo, hi;
    logic              in_win;
    logic [1:0]        nxt_pol;
    logic [6:0]        w_sum;
    logic [5:0]        nxt_width;

    always_comb begin
        lo_diff   = {1'b0, target_q} - {1'b0, tol_q};
        hi_sum    = {1'b0, target_q} + {1'b0, tol_q};
        lo        = lo_diff[ADC_W] ? '0 : lo_diff[ADC_W-1:0];
        hi        = hi_sum[ADC_W]  ? '1 : hi_sum[ADC_W-1:0];
        in_win    = (last_adc >= lo) && (last_adc <= hi);
        nxt_pol   = (last_adc < lo) ? 2'd1 : 2'd2;
        w_sum     = {1'b0, width_q} + {1'b0, w_step_q};
        // Same polarity as last pulse grows the width; any change restarts it.
        if (nxt_pol == prev_pol)
            nxt_width = (w_sum > WMAX7) ? WMAX7[5:0] : w_sum[5:0];
        else
            nxt_width = w_init_q;
    end

    task automatic finish_run(input logic [1:0] st);
        state    <= S_END;
        status   <= st;
        busy     <= 1'b0;
        done     <= 1'b1;
        pcb_mode <= 3'd0;
        pulse_dw <= 8'd0;
    endtask

    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            state      <= S_IDLE;
            cnt        <= '0;
            target_q   <= '0;
            tol_q      <= '0;
            max_iter_q <= '0;
            w_init_q   <= '0;
            w_step_q   <= '0;
            width_q    <= '0;
            prev_pol   <= '0;
            abort_seen <= 1'b0;
            pcb_mode   <= 3'd0;
            pulse_dw   <= 8'd0;
            adc_start  <= 1'b0;
            pls_start  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            status     <= 2'd0;
            iter_cnt   <= '0;
            last_adc   <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: if (go) begin
                    target_q   <= target;
                    tol_q      <= tol;
                    max_iter_q <= max_iter;
                    w_init_q   <= w_init;
                    w_step_q   <= w_step;
                    width_q    <= '0;
                    prev_pol   <= '0;
                    abort_seen <= 1'b0;
                    iter_cnt   <= '0;
                    status     <= 2'd0;
                    busy       <= 1'b1;
                    cnt        <= '0;
                    state      <= S_SET_R;
                end
                S_SET_R: begin
                    if (abort) finish_run(2'd3);
                    else if (cnt == SETTLE_LAST) begin
                        cnt   <= '0;
                        state <= S_RD_REQ;
                    end else cnt <= cnt + 1'b1;
                end
                S_RD_REQ: begin
                    adc_start <= ~adc_start;
                    cnt       <= '0;
                    state     <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    // The request is never cancelled; abort is remembered for later.
                    if (abort) abort_seen <= 1'b1;
                    if (adc_finish == adc_start) begin
                        last_adc <= adc_data;
                        state    <= S_EVAL;
                    end else if (cnt == TIMEOUT_LAST) finish_run(2'd2);
                    else cnt <= cnt + 1'b1;
                end
                S_EVAL: begin
                    if (abort || abort_seen)  finish_run(2'd3);
                    else if (in_win)          finish_run(2'd0);
                    else if (iter_cnt == max_iter_q) finish_run(2'd1);
                    else begin
                        prev_pol <= nxt_pol;
                        width_q  <= nxt_width;
                        pulse_dw <= {nxt_pol, nxt_width};
                        pcb_mode <= 3'd1;
                        cnt      <= '0;
                        state    <= S_SET_W;
                    end
                end
                S_SET_W: begin
                    if (abort) finish_run(2'd3);
                    else if (cnt == SETTLE_LAST) begin
                        cnt   <= '0;
                        state <= S_PL_REQ;
                    end else cnt <= cnt + 1'b1;
                end
                S_PL_REQ: begin
                    pls_start <= ~pls_start;
                    if (iter_cnt != '1) iter_cnt <= iter_cnt + 1'b1;
                    cnt   <= '0;
                    state <= S_PL_WAIT;
                end
                S_PL_WAIT: begin
                    if (abort) abort_seen <= 1'b1;
                    if (pls_finish == pls_start) begin
                        if (abort || abort_seen) finish_run(2'd3);
                        else begin
                            pcb_mode      <= 3'd0;
                            pulse_dw[7:6] <= 2'd0;
                            cnt           <= '0;
                            state         <= S_SET_R;
                        end
                    end else if (cnt == TIMEOUT_LAST) finish_run(2'd2);
                    else cnt <= cnt + 1'b1;
                end
                S_END:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wv_sequencer.sv
`default_nettype none
// ============================================================================
// tb_wv_sequencer : randomized bench with ADC / pulse-generator peers and a loop model
// Revision        : 1.0
// ============================================================================
module tb_wv_sequencer;

    localparam int SETTLE = 8;
    localparam int TMO    = 100;

    logic        clk_in = 1'b0, rstn = 1'b0, go = 1'b0, abort = 1'b0;
    logic [15:0] target = '0, tol = '0;
    logic [7:0]  max_iter = '0;
    logic [5:0]  w_init = '0, w_step = '0;
    logic [2:0]  pcb_mode;
    logic [7:0]  pulse_dw;
    logic        adc_start, pls_start, busy, done;
    logic        adc_finish = 1'b0, pls_finish = 1'b0;
    logic [15:0] adc_data = '0;
    logic [1:0]  status;
    logic [7:0]  iter_cnt;
    logic [15:0] last_adc;

    wv_sequencer #(.ADC_W(16), .ITER_W(8), .SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TMO), .W_MAX(63)) dut (
        .clk_in(clk_in), .rstn(rstn), .go(go), .abort(abort), .target(target), .tol(tol),
        .max_iter(max_iter), .w_init(w_init), .w_step(w_step), .pcb_mode(pcb_mode),
        .pulse_dw(pulse_dw), .adc_start(adc_start), .adc_finish(adc_finish), .adc_data(adc_data),
        .pls_start(pls_start), .pls_finish(pls_finish), .busy(busy), .done(done),
        .status(status), .iter_cnt(iter_cnt), .last_adc(last_adc)
    );

    always #5 clk_in = ~clk_in;

    int total = 0, bad = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Peer and monitor state
    int         seq [32];
    int         seq_len = 1;
    int         rd_cnt = 0, adc_dly = 0, pls_dly = 0;
    bit         adc_pend = 0, pls_pend = 0, pls_hang = 0;
    logic [7:0] got_pw [$];
    int         cyc = 0, mode_age = 0, mode_hi = 0;
    logic [2:0] prev_mode = 3'd0;
    int         done_cnt = 0, done_cyc = 0, req_cyc = 0;
    int         abort_ph = 0;

    always @(negedge clk_in) begin
        cyc++;
        if (pcb_mode !== prev_mode) mode_age = 0; else mode_age++;
        prev_mode = pcb_mode;
        if (int'(pcb_mode) > mode_hi) mode_hi = int'(pcb_mode);
        if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
        if (!rstn) begin
            adc_finish = 1'b0; pls_finish = 1'b0; adc_pend = 0; pls_pend = 0;
        end else begin
            if (abort_ph == 2) begin abort = 1'b0; abort_ph = 0; end
            if (abort_ph == 1 && adc_start !== adc_finish) begin abort = 1'b1; abort_ph = 2; end
            if (!adc_pend && adc_start !== adc_finish) begin
                adc_pend = 1; adc_dly = int'($urandom_range(0, 3));
                check("adc_req_mode", pcb_mode, 0);
                check("adc_req_settle", longint'(mode_age >= SETTLE), 1);
            end else if (adc_pend) begin
                if (adc_dly == 0) begin
                    adc_data = 16'(seq[rd_cnt < seq_len ? rd_cnt : seq_len - 1]);
                    rd_cnt++;
                    adc_finish = ~adc_finish; adc_pend = 0;
                end else adc_dly--;
            end
            if (!pls_pend && pls_start !== pls_finish) begin
                pls_pend = 1; pls_dly = int'($urandom_range(0, 3)); req_cyc = cyc;
                got_pw.push_back(pulse_dw);
                check("pls_req_mode", pcb_mode, 1);
                check("pls_req_settle", longint'(mode_age >= SETTLE), 1);
            end else if (pls_pend && !pls_hang) begin
                if (pls_dly == 0) begin pls_finish = ~pls_finish; pls_pend = 0; end
                else pls_dly--;
            end
        end
    end

    // Reference: the write-verify loop evaluated directly on the sample stream.
    int         exp_status, exp_iter, exp_reads, exp_last;
    logic [7:0] exp_pw [$];

    task automatic model(input int tg, input int tl, input int mi, input int wi, input int ws, input bit hang);
        int lo, hi, n, pp, w, r, v, pol;
        lo = tg - tl; if (lo < 0) lo = 0;
        hi = tg + tl; if (hi > 65535) hi = 65535;
        exp_pw.delete();
        n = 0; pp = 0; w = 0; r = 0;
        while (1) begin
            v = seq[r < seq_len ? r : seq_len - 1];
            r++;
            exp_last = v; exp_reads = r;
            if (v >= lo && v <= hi) begin exp_status = 0; break; end
            if (n == mi) begin exp_status = 1; break; end
            pol = (v < lo) ? 1 : 2;
            w = (pol == pp) ? ((w + ws > 63) ? 63 : w + ws) : wi;
            pp = pol;
            exp_pw.push_back(8'(pol * 64 + w));
            n++;
            if (hang) begin exp_status = 2; break; end
        end
        exp_iter = n;
    endtask

    task automatic set_seq(input int n, input int a, input int b, input int c, input int d);
        seq[0] = a; seq[1] = b; seq[2] = c; seq[3] = d; seq_len = n;
    endtask

    // amode: 0 none, 1 abort together with go, 2 abort during first read wait
    task automatic run_case(input string nm, input int tg, input int tl, input int mi,
                            input int wi, input int ws, input bit hang, input int amode);
        int d0, t0, np;
        model(tg, tl, mi, wi, ws, hang);
        if (amode == 2) begin
            exp_status = 3; exp_iter = 0; exp_reads = 1; exp_last = seq[0]; exp_pw.delete();
        end
        pls_hang = hang; rd_cnt = 0; got_pw.delete(); mode_hi = 0;
        target = 16'(tg); tol = 16'(tl); max_iter = 8'(mi); w_init = 6'(wi); w_step = 6'(ws);
        @(negedge clk_in);
        go = 1'b1;
        if (amode == 1) abort = 1'b1;
        if (amode == 2) abort_ph = 1;
        @(negedge clk_in);
        go = 1'b0;
        if (amode == 1) abort = 1'b0;
        check({nm, ".busy"}, busy, 1);
        d0 = done_cnt; t0 = cyc;
        while (done_cnt == d0 && cyc - t0 < 20000) @(negedge clk_in);
        @(negedge clk_in);
        check({nm, ".done_seen"}, done_cnt - d0, 1);
        check({nm, ".done_low"}, done, 0);
        check({nm, ".busy_low"}, busy, 0);
        check({nm, ".status"}, status, exp_status);
        check({nm, ".iter"}, iter_cnt, exp_iter);
        check({nm, ".last_adc"}, last_adc, exp_last);
        check({nm, ".reads"}, rd_cnt, exp_reads);
        check({nm, ".npulses"}, got_pw.size(), exp_pw.size());
        np = (got_pw.size() < exp_pw.size()) ? got_pw.size() : exp_pw.size();
        for (int i = 0; i < np; i++) check({nm, ".pulse_dw"}, got_pw[i], exp_pw[i]);
        check({nm, ".end_mode"}, pcb_mode, 0);
        check({nm, ".end_dw"}, pulse_dw, 0);
        if (exp_pw.size() == 0) check({nm, ".mode_stays_r"}, mode_hi, 0);
        if (hang) check({nm, ".tmo_cycles"}, done_cyc - req_cyc, TMO);
        else      check({nm, ".adc_tog_eq"}, longint'(adc_start == adc_finish), 1);
    endtask

    task automatic pulse_reset();
        rstn = 1'b0;
        repeat (2) @(negedge clk_in);
        rstn = 1'b1;
        @(negedge clk_in);
    endtask

    initial begin
        int tg, tl, off, v, t0;
        repeat (3) @(negedge clk_in);
        check("rst.pcb_mode", pcb_mode, 0);
        check("rst.pulse_dw", pulse_dw, 0);
        check("rst.toggles", {adc_start, pls_start}, 0);
        check("rst.busy_done", {busy, done}, 0);
        check("rst.status", status, 0);
        check("rst.iter", iter_cnt, 0);
        check("rst.last_adc", last_adc, 0);
        rstn = 1'b1;
        @(negedge clk_in);

        set_seq(1, 1010, 0, 0, 0);       run_case("pass_first", 1000, 20, 5, 4, 4, 0, 0);
        set_seq(4, 900, 940, 970, 985);  run_case("set_ramp", 1000, 20, 8, 4, 4, 0, 0);
        check("set_ramp.w3", got_pw.size() == 3 ? got_pw[2] : 0, 8'h4C);
        set_seq(3, 1100, 900, 900, 0);   run_case("pol_flip", 1000, 20, 2, 4, 4, 0, 0);
        set_seq(1, 0, 0, 0, 0);          run_case("w_ceiling", 1000, 20, 3, 60, 5, 0, 0);
        set_seq(2, 979, 980, 0, 0);      run_case("lo_edge", 1000, 20, 4, 4, 4, 0, 0);
        set_seq(2, 1021, 1020, 0, 0);    run_case("hi_edge", 1000, 20, 4, 4, 4, 0, 0);
        set_seq(1, 0, 0, 0, 0);          run_case("lo_sat", 10, 20, 4, 4, 4, 0, 0);
        set_seq(1, 65535, 0, 0, 0);      run_case("hi_sat", 65530, 20, 4, 4, 4, 0, 0);
        set_seq(1, 500, 0, 0, 0);        run_case("read_only", 1000, 20, 0, 4, 4, 0, 0);
        set_seq(1, 1010, 0, 0, 0);       run_case("go_abort", 1000, 20, 5, 4, 4, 0, 1);
        set_seq(2, 900, 1000, 0, 0);     run_case("abort_rd", 1000, 20, 5, 4, 4, 0, 2);
        check("post_abort.tog_eq", longint'(adc_start == adc_finish), 1);
        set_seq(2, 900, 1000, 0, 0);     run_case("after_abort", 1000, 20, 5, 4, 4, 0, 0);
        set_seq(1, 0, 0, 0, 0);          run_case("timeout", 1000, 20, 5, 4, 4, 1, 0);
        pulse_reset();
        pls_hang = 0;

        // Reset while the pulse generator has not answered.
        set_seq(1, 0, 0, 0, 0);
        pls_hang = 1; rd_cnt = 0; got_pw.delete();
        target = 16'd1000; tol = 16'd20; max_iter = 8'd3; w_init = 6'd4; w_step = 6'd4;
        @(negedge clk_in); go = 1'b1;
        @(negedge clk_in); go = 1'b0;
        t0 = cyc;
        while (!pls_pend && cyc - t0 < 2000) @(negedge clk_in);
        check("rst_pl.reached", longint'(pls_pend), 1);
        @(negedge clk_in);
        rstn = 1'b0;
        @(negedge clk_in);
        check("rst_pl.outs", {pcb_mode, pulse_dw, adc_start, pls_start, busy, done, status}, 0);
        check("rst_pl.iter", iter_cnt, 0);
        check("rst_pl.last_adc", last_adc, 0);
        @(negedge clk_in);
        rstn = 1'b1; pls_hang = 0;
        @(negedge clk_in);
        set_seq(3, 1100, 1000, 0, 0);    run_case("after_rst", 1000, 20, 5, 7, 3, 0, 0);

        for (int k = 0; k < 40; k++) begin
            tg = int'($urandom_range(0, 65535));
            if (k % 5 == 0) tg = int'($urandom_range(0, 100));
            if (k % 5 == 1) tg = 65535 - int'($urandom_range(0, 100));
            tl = int'($urandom_range(0, 300));
            seq_len = 8;
            for (int i = 0; i < 8; i++) begin
                off = int'($urandom_range(0, 2 * tl + 800));
                v = tg + off - tl - 400;
                if (v < 0) v = 0;
                if (v > 65535) v = 65535;
                seq[i] = v;
            end
            run_case("rand", tg, tl, int'($urandom_range(0, 6)), int'($urandom_range(0, 63)),
                     int'($urandom_range(0, 63)), 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
